// File: rtl/add_sub_arbiter.sv
// Two-requester arbiter in front of one registered add/subtract unit.
// Round-robin or fixed-priority grant, two-stage pipeline, response tagged with requester id.
module add_sub_arbiter #(
  parameter int WIDTH = 8,
  parameter bit RR    = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sel,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_s,
  output logic             rsp_cout,
  output logic             rsp_ovf
);

  // Result packing: {ovf, cout, s}; subtraction is a + ~b + 1
  function automatic logic [WIDTH+1:0] addsub(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic             sel);
    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   sum;
    logic             ovf;
    bx  = b ^ {WIDTH{sel}};
    sum = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sel};
    ovf = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    return {ovf, sum};
  endfunction

  logic             ptr_r;
  logic             gnt0_s;
  logic             gnt1_s;
  logic             xfer_s;
  logic [WIDTH-1:0] mux_a_s;
  logic [WIDTH-1:0] mux_b_s;
  logic             mux_sel_s;

  logic             s1_valid_r;
  logic             s1_id_r;
  logic [WIDTH-1:0] s1_a_r;
  logic [WIDTH-1:0] s1_b_r;
  logic             s1_sel_r;
  logic [WIDTH+1:0] s1_res_s;

  logic             rsp_valid_r;
  logic             rsp_id_r;
  logic [WIDTH-1:0] rsp_s_r;
  logic             rsp_cout_r;
  logic             rsp_ovf_r;

  // Grant: held off during reset, pointer breaks ties only when round-robin is enabled
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (!rst_n) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (req0_valid && req1_valid) begin
      if ((RR == 1'b1) && ptr_r) begin
        gnt1_s = 1'b1;
      end else begin
        gnt0_s = 1'b1;
      end
    end else if (req0_valid) begin
      gnt0_s = 1'b1;
    end else if (req1_valid) begin
      gnt1_s = 1'b1;
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  assign req0_ready = gnt0_s;
  assign req1_ready = gnt1_s;
  assign xfer_s     = gnt0_s | gnt1_s;

  // Operand select for the granted requester
  always_comb begin
    mux_a_s   = req0_a;
    mux_b_s   = req0_b;
    mux_sel_s = req0_sel;
    if (gnt1_s) begin
      mux_a_s   = req1_a;
      mux_b_s   = req1_b;
      mux_sel_s = req1_sel;
    end else begin
      mux_a_s   = req0_a;
      mux_b_s   = req0_b;
      mux_sel_s = req0_sel;
    end
  end

  // Round-robin pointer: favour the requester that was not just served
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= 1'b0;
    end else if ((RR == 1'b1) && xfer_s) begin
      ptr_r <= ~gnt1_s;
    end
  end

  // Stage 1: capture the granted operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_id_r    <= 1'b0;
      s1_a_r     <= {WIDTH{1'b0}};
      s1_b_r     <= {WIDTH{1'b0}};
      s1_sel_r   <= 1'b0;
    end else begin
      s1_valid_r <= xfer_s;
      if (xfer_s) begin
        s1_id_r  <= gnt1_s;
        s1_a_r   <= mux_a_s;
        s1_b_r   <= mux_b_s;
        s1_sel_r <= mux_sel_s;
      end
    end
  end

  assign s1_res_s = addsub(s1_a_r, s1_b_r, s1_sel_r);

  // Stage 2: register the result; fields hold their last value between pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= 1'b0;
      rsp_s_r     <= {WIDTH{1'b0}};
      rsp_cout_r  <= 1'b0;
      rsp_ovf_r   <= 1'b0;
    end else begin
      rsp_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        rsp_id_r   <= s1_id_r;
        rsp_s_r    <= s1_res_s[WIDTH-1:0];
        rsp_cout_r <= s1_res_s[WIDTH];
        rsp_ovf_r  <= s1_res_s[WIDTH+1];
      end
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_s     = rsp_s_r;
  assign rsp_cout  = rsp_cout_r;
  assign rsp_ovf   = rsp_ovf_r;

endmodule

// File: tb/tb_add_sub_arbiter.sv
// Bench for add_sub_arbiter: round-robin and fixed-priority instances on shared inputs,
// directed vectors plus randomized traffic against an arithmetic reference model.
module tb_add_sub_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_sel, req1_sel;

  logic       rr_r0, rr_r1, rr_v, rr_id, rr_c, rr_o;
  logic [7:0] rr_s;
  logic       fp_r0, fp_r1, fp_v, fp_id, fp_c, fp_o;
  logic [7:0] fp_s;

  int n_tests = 0;
  int n_fail  = 0;

  add_sub_arbiter #(.WIDTH(8), .RR(1'b1)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(rr_r0), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(rr_r1), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .rsp_valid(rr_v), .rsp_id(rr_id), .rsp_s(rr_s), .rsp_cout(rr_c), .rsp_ovf(rr_o));

  add_sub_arbiter #(.WIDTH(8), .RR(1'b0)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(fp_r0), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(fp_r1), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .rsp_valid(fp_v), .rsp_id(fp_id), .rsp_s(fp_s), .rsp_cout(fp_c), .rsp_ovf(fp_o));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference arithmetic from plain integer rules
  task automatic ref_op(input int a, input int b, input bit sel,
                        output logic [7:0] s, output logic cout, output logic ovf);
    int sa, sb, full, r;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    if (!sel) begin
      full = a + b;
      cout = (full > 255);
      r    = sa + sb;
    end else begin
      full = a - b;
      cout = (a >= b);
      r    = sa - sb;
    end
    s   = 8'(full & 255);
    ovf = (r > 127) || (r < -128);
  endtask

  typedef struct {
    logic [7:0] a, b;
    logic       sel, id;
    logic [7:0] s;
    logic       cout, ovf;
  } vec_t;

  typedef struct {
    int         due;
    logic       id;
    logic [7:0] s;
    logic       cout, ovf;
  } exp_t;

  vec_t tbl[7];
  exp_t q[$];

  task automatic set_req(input logic id, input logic [7:0] a, input logic [7:0] b, input logic sel);
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sel = sel;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sel = sel;
    end
  endtask

  initial begin
    logic       ptr_m, hold0, hold1, g0, g1, k;
    logic [7:0] es;
    logic       ec, eo;
    int         cyc;
    exp_t       e;

    tbl[0] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[1] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};
    tbl[2] = '{8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0};
    tbl[3] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[4] = '{8'h80, 8'h80, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1};
    tbl[5] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[6] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1};

    // Reset held with both requesters valid
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_a = 8'hFF; req0_b = 8'h01; req0_sel = 1'b0;
    req1_valid = 1'b1; req1_a = 8'h05; req1_b = 8'h07; req1_sel = 1'b1;
    #12;
    chk("rst_ready0", 32'(rr_r0), 32'd0);
    chk("rst_ready1", 32'(rr_r1), 32'd0);
    chk("rst_outputs", 32'({rr_v, rr_id, rr_s, rr_c, rr_o}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready0", 32'(rr_r0), 32'd1);
    chk("post_rst_ready1", 32'(rr_r1), 32'd0);

    // Round-robin contention; fixed-priority instance sees the same traffic
    for (int i = 0; i < 6; i++) begin
      if (i == 4) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
      #1;
      if (i < 4) begin
        chk("rr_grant0", 32'(rr_r0), 32'((i % 2) == 0));
        chk("rr_grant1", 32'(rr_r1), 32'((i % 2) == 1));
        chk("fp_grant0", 32'(fp_r0), 32'd1);
        chk("fp_grant1", 32'(fp_r1), 32'd0);
      end
      if (i >= 2) begin
        chk("rr_rsp_valid", 32'(rr_v), 32'd1);
        chk("rr_rsp_id", 32'(rr_id), 32'((i - 2) % 2));
        chk("rr_rsp_s", 32'(rr_s), ((i - 2) % 2 == 0) ? 32'h00 : 32'hFE);
        chk("rr_rsp_cout", 32'(rr_c), ((i - 2) % 2 == 0) ? 32'd1 : 32'd0);
      end
      @(posedge clk); #1;
    end

    // Fixed priority: req0 drops, req1 granted in the same cycle
    req1_valid = 1'b1;
    #1;
    chk("fp_req1_alone", 32'(fp_r1), 32'd1);
    req1_valid = 1'b0;
    @(posedge clk); #1;

    // Single operations from the table
    for (int i = 0; i < 7; i++) begin
      set_req(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].sel);
      #1;
      chk("tbl_ready", 32'(tbl[i].id ? rr_r1 : rr_r0), 32'd1);
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk("tbl_latency", 32'(rr_v), 32'd0);
      @(posedge clk); #1;
      chk("tbl_valid", 32'(rr_v), 32'd1);
      chk("tbl_id", 32'(rr_id), 32'(tbl[i].id));
      chk("tbl_s", 32'(rr_s), 32'(tbl[i].s));
      chk("tbl_cout", 32'(rr_c), 32'(tbl[i].cout));
      chk("tbl_ovf", 32'(rr_o), 32'(tbl[i].ovf));
    end
    @(posedge clk); #1;
    chk("pulse_once", 32'(rr_v), 32'd0);
    chk("hold_s", 32'(rr_s), 32'h7F);

    // Reset mid-flight: one response showing, one still in the pipe
    set_req(1'b0, 8'h11, 8'h22, 1'b0);
    @(posedge clk); #1;
    set_req(1'b0, 8'h33, 8'h01, 1'b0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    chk("mid_pre_valid", 32'(rr_v), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_async_clear", 32'(rr_v), 32'd0);
    @(posedge clk); #1;
    chk("mid_in_reset", 32'(rr_v), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("mid_no_stale", 32'(rr_v), 32'd0);
      chk("mid_s_zero", 32'(rr_s), 32'd0);
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("mid_ptr_reset", 32'(rr_r0), 32'd1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;

    // Randomized traffic against the model
    ptr_m = 1'b0; hold0 = 1'b0; hold1 = 1'b0; cyc = 0;
    for (int c = 0; c < 400; c++) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk("rnd_valid", 32'(rr_v), 32'd1);
        chk("rnd_id", 32'(rr_id), 32'(e.id));
        chk("rnd_s", 32'(rr_s), 32'(e.s));
        chk("rnd_cout", 32'(rr_c), 32'(e.cout));
        chk("rnd_ovf", 32'(rr_o), 32'(e.ovf));
      end else begin
        chk("rnd_idle", 32'(rr_v), 32'd0);
      end
      if (!hold0) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_a = 8'($urandom); req0_b = 8'($urandom); req0_sel = 1'($urandom);
      end
      if (!hold1) begin
        req1_valid = ($urandom_range(0, 3) != 0);
        req1_a = 8'($urandom); req1_b = 8'($urandom); req1_sel = 1'($urandom);
      end
      #1;
      g0 = 1'b0; g1 = 1'b0;
      if (req0_valid && req1_valid) begin
        if (ptr_m) g1 = 1'b1; else g0 = 1'b1;
      end else begin
        g0 = req0_valid;
        g1 = req1_valid;
      end
      chk("rnd_ready0", 32'(rr_r0), 32'(g0));
      chk("rnd_ready1", 32'(rr_r1), 32'(g1));
      if (g0 || g1) begin
        k = g1;
        if (k) ref_op(int'(req1_a), int'(req1_b), req1_sel, es, ec, eo);
        else   ref_op(int'(req0_a), int'(req0_b), req0_sel, es, ec, eo);
        q.push_back('{cyc + 2, k, es, ec, eo});
        ptr_m = ~k;
      end
      hold0 = req0_valid && !g0;
      hold1 = req1_valid && !g1;
      @(posedge clk); #1;
      cyc++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk("drain_valid", 32'(rr_v), 32'd1);
        chk("drain_s", 32'(rr_s), 32'(e.s));
      end else begin
        chk("drain_idle", 32'(rr_v), 32'd0);
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("drain_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
